// File: rtl/multi_debouncer_if.sv
// Switch/debounce bundle: raw switch levels in, clean levels and edge pulses out.
interface multi_debouncer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic [N-1:0] db;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  modport master (output sw, input db, input rise, input fall);
  modport slave  (input sw, output db, output rise, output fall);
endinterface

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer sharing one sampling tick generator.
//
// state | meaning
// ------+--------------------------------------------------------------
// ZERO  | debounced level 0, synchronised input agrees
// WAIT1 | level 0, input high; counting stable ticks towards ONE
// ONE   | debounced level 1, synchronised input agrees
// WAIT0 | level 1, input low; counting stable ticks towards ZERO
module multi_debouncer #(
  parameter int N            = 4,
  parameter int TICK_M       = 500_000,
  parameter int STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  multi_debouncer_if.slave bus
);

  localparam int TW = $clog2(TICK_M);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_M - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic [N-1:0] s1;
  logic [N-1:0] sw_s;

  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];

  logic [N-1:0] db_lvl;
  logic [N-1:0] rise_set;
  logic [N-1:0] fall_set;
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sampling tick shared by every channel.
  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Two-flop synchroniser on the raw switch inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      sw_s <= '0;
    end else begin
      s1   <= bus.sw;
      sw_s <= s1;
    end
  end

  // Per-channel state and stable-tick counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic; a bounce takes priority over a coincident tick.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ZERO: begin
          if (sw_s[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          if (!sw_s[i]) begin
            state_d[i] = ZERO;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ONE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        ONE: begin
          if (!sw_s[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (sw_s[i]) begin
            state_d[i] = ONE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ZERO;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = ZERO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Moore level output and edge detection on the committed transitions.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      db_lvl[i]   = (state_q[i] == ONE) || (state_q[i] == WAIT0);
      rise_set[i] = (state_q[i] == WAIT1) && (state_d[i] == ONE);
      fall_set[i] = (state_q[i] == WAIT0) && (state_d[i] == ZERO);
    end
  end

  // Edge pulses registered so they line up with the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_set;
      fall_q <= fall_set;
    end
  end

  assign bus.db   = db_lvl;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Randomised and directed bench for multi_debouncer against a tick-counting reference model.
module tb_multi_debouncer;

  localparam int N  = 2;
  localparam int TM = 4;
  localparam int ST = 3;

  logic clk;
  logic reset;

  int errors;
  int checks;

  // reference model state
  logic [N-1:0] m_s1, m_ss, m_db, m_rise, m_fall;
  int           m_since [N];
  int           m_k;

  multi_debouncer_if #(.N(N)) dbif ();

  multi_debouncer #(
    .N            (N),
    .TICK_M       (TM),
    .STABLE_TICKS (ST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // number of tick cycles with index in [0, x]
  function automatic int ticks_upto(input int x);
    return (x + 1) / TM;
  endfunction

  // ticks accumulated so far by a channel that is waiting, -1 if not waiting
  function automatic int m_wait_ticks(input int i);
    if (m_since[i] < 0) return -1;
    return ticks_upto(m_k - 1) - ticks_upto(m_since[i]);
  endfunction

  task automatic model_edge(input logic [N-1:0] s, input logic r);
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_s1 = '0;
      m_ss = '0;
      m_db = '0;
      for (int i = 0; i < N; i++) m_since[i] = -1;
      m_k = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_ss[i] == m_db[i]) begin
          m_since[i] = -1;
        end else if (m_since[i] < 0) begin
          m_since[i] = m_k;
        end else if (ticks_upto(m_k) - ticks_upto(m_since[i]) >= ST) begin
          m_db[i] = ~m_db[i];
          if (m_db[i]) m_rise[i] = 1'b1;
          else         m_fall[i] = 1'b1;
          m_since[i] = -1;
        end
      end
      m_ss = m_s1;
      m_s1 = s;
      m_k++;
    end
  endtask

  // drive one cycle, advance model, compare on the falling edge
  task automatic step(input logic [N-1:0] s, input logic r);
    dbif.sw = s;
    reset   = r;
    @(posedge clk);
    model_edge(s, r);
    @(negedge clk);
    check("db",   32'(dbif.db),   32'(m_db));
    check("rise", 32'(dbif.rise), 32'(m_rise));
    check("fall", 32'(dbif.fall), 32'(m_fall));
  endtask

  // apply a level, measure latency until db reaches exp_db, then hold for total cycles
  task automatic settle(input logic [N-1:0] s, input logic [N-1:0] exp_db, input int total,
                        input string tag);
    int lat;
    lat = 0;
    while (dbif.db !== exp_db && lat < 40) begin
      step(s, 1'b0);
      lat++;
    end
    check(tag, 32'(lat >= 10 && lat <= 15), 32'd1);
    for (int c = lat; c < total; c++) step(s, 1'b0);
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] db_ref;
    logic         changed;
    logic         pulsed;
    int           lat;
    int           guard;

    errors = 0;
    checks = 0;
    reset  = 1'b1;
    dbif.sw = '0;
    m_s1 = '0; m_ss = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < N; i++) m_since[i] = -1;
    m_k = 0;

    // reset with both switches held high
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    check("rst_db", 32'(dbif.db), 32'd0);
    lat = 0;
    while (dbif.db !== 2'b11 && lat < 40) begin
      step(2'b11, 1'b0);
      lat++;
    end
    check("rst_rel_lat", 32'(lat >= 10 && lat <= 15), 32'd1);
    check("rst_rel_rise", 32'(dbif.rise), 32'h3);

    // clean press and release on channel 0
    step(2'b00, 1'b1);
    repeat (10) step(2'b00, 1'b0);
    settle(2'b01, 2'b01, 20, "press_lat");
    settle(2'b00, 2'b00, 20, "release_lat");

    // bounce on channel 0 faster than a tick
    changed = 1'b0;
    pulsed  = 1'b0;
    cur     = 2'b00;
    for (int t = 0; t < 20; t++) begin
      cur[0] = ~cur[0];
      repeat (3) begin
        step(cur, 1'b0);
        if (dbif.db[0] !== 1'b0) changed = 1'b1;
        if (dbif.rise[0] || dbif.fall[0]) pulsed = 1'b1;
      end
    end
    check("bounce_db", 32'(changed), 32'd0);
    check("bounce_pulse", 32'(pulsed), 32'd0);
    settle(2'b01, 2'b01, 20, "bounce_hold");

    // short glitch on channel 1, low then high level
    changed = 1'b0;
    pulsed  = 1'b0;
    repeat (6) begin
      step(2'b11, 1'b0);
      if (dbif.db[1] || dbif.rise[1]) changed = 1'b1;
    end
    repeat (20) begin
      step(2'b01, 1'b0);
      if (dbif.db[1] || dbif.rise[1]) changed = 1'b1;
    end
    check("glitch_hi", 32'(changed), 32'd0);
    settle(2'b11, 2'b11, 20, "ch1_up");
    changed = 1'b0;
    repeat (6) begin
      step(2'b01, 1'b0);
      if (!dbif.db[1] || dbif.fall[1]) changed = 1'b1;
    end
    repeat (20) begin
      step(2'b11, 1'b0);
      if (!dbif.db[1] || dbif.fall[1]) changed = 1'b1;
    end
    check("glitch_lo", 32'(changed), 32'd0);

    // reset while channel 0 waits with two ticks counted
    step(2'b00, 1'b1);
    repeat (10) step(2'b00, 1'b0);
    guard = 0;
    while (m_wait_ticks(0) != 2 && guard < 40) begin
      step(2'b01, 1'b0);
      guard++;
    end
    check("reach_wait2", 32'(guard < 40), 32'd1);
    step(2'b01, 1'b1);
    check("rst_wait_db", 32'(dbif.db), 32'd0);
    check("rst_wait_pulse", 32'(dbif.rise | dbif.fall), 32'd0);
    settle(2'b01, 2'b01, 20, "after_rst_lat");
    step(2'b01, 1'b1);
    check("rst_one_db", 32'(dbif.db), 32'd0);
    check("rst_one_fall", 32'(dbif.fall), 32'd0);
    repeat (5) step(2'b00, 1'b0);

    // both channels together
    step(2'b00, 1'b1);
    repeat (7) step(2'b00, 1'b0);
    lat = 0;
    while (dbif.db === 2'b00 && lat < 40) begin
      step(2'b11, 1'b0);
      lat++;
    end
    check("simul_db", 32'(dbif.db), 32'h3);
    check("simul_rise", 32'(dbif.rise), 32'h3);
    repeat (5) step(2'b11, 1'b0);

    // randomised traffic
    cur = 2'b00;
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(cur, 1'b1);
      end
      cur = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 18)) step(cur, 1'b0);
    end

    db_ref = m_db;
    check("final_db", 32'(dbif.db), 32'(db_ref));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised N-channel switch/button debouncer: the successor to the single-channel delayed debouncer. Each channel synchronises its raw input, requires a configurable number of consecutive stable ticks before changing its debounced level, and emits one-cycle rise/fall pulses. A single shared tick generator serves all channels. Sits between raw board switches/keys and the control FSMs that consume clean levels or edge events.

## Interface
- `N`, 4: number of independent channels.
- `TICK_M`, 500_000: clock cycles per sampling tick (10 ms at 50 MHz); legal values ≥ 2.
- `STABLE_TICKS`, 3: consecutive ticks of stable input required to change level; legal values ≥ 1.
- `clk`  in  1  system clock (one clock domain).
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  N  raw asynchronous switch inputs.
- `db`  out  N  debounced levels.
- `rise`  out  N  one-cycle pulse per channel when `db` goes 0→1.
- `fall`  out  N  one-cycle pulse per channel when `db` goes 1→0.

## Operation
- Tick generator: free-running counter, width `$clog2(TICK_M)`, counts 0..TICK_M-1 and wraps. `tick` is 1 in the cycle the count equals TICK_M-1. One generator is shared by all channels.
- Synchroniser: per channel, two flops, `sw` → `s1` → `sw_s`. All FSM decisions use `sw_s` only.
- Per-channel FSM with states ZERO, WAIT1, ONE, WAIT0. Each channel also has a tick counter `cnt`, width `$clog2(STABLE_TICKS+1)`.
  - ZERO: if `sw_s`=1, go to WAIT1 and set cnt=0; otherwise stay.
  - WAIT1: if `sw_s`=0, go to ZERO (cnt=0). Otherwise, if `tick`: when cnt==STABLE_TICKS-1, go to ONE; else cnt++. The `sw_s`=0 check has priority over `tick` in the same cycle.
  - ONE: mirror of ZERO. If `sw_s`=0, go to WAIT0 with cnt=0.
  - WAIT0: mirror of WAIT1. If `sw_s`=1, return to ONE. When cnt reaches STABLE_TICKS-1 on a tick, go to ZERO.
  - Unreachable encodings go to ZERO. A channel can never leave all outputs stuck: every state has a defined exit for both `sw_s` values.
- Outputs:
  - `db[i]` = 1 in ONE and WAIT0, 0 in ZERO and WAIT1 (Moore).
  - `rise[i]` is a registered flag, set for exactly the one cycle following the WAIT1→ONE transition. `fall[i]` is the same for WAIT0→ZERO.
- Channels are fully independent. Any mix of channels may change or pulse in the same cycle.
- Boundary behaviour:
  - A bounce aborts the wait and the counter restarts from 0 on the next qualifying edge. No partial credit is kept.
  - Input toggling faster than one tick never changes `db`, however long it continues.

## Timing
- Reset (synchronous, sampled on the `clk` rising edge):
  - Tick counter = 0.
  - Synchroniser flops = 0.
  - All FSMs = ZERO, all cnt = 0.
  - `db`, `rise`, `fall` = 0 from the first edge with `reset`=1.
- Reset asserted mid-wait or mid-pulse: the pending transition and any pulse are discarded. No `fall` is generated for a channel forced from ONE to ZERO.
- Synchroniser latency: 2 cycles from `sw` to `sw_s`. The FSM reacts on the 3rd edge.
- Debounce latency: `db` changes no earlier than 2+(STABLE_TICKS-1)·TICK_M cycles and no later than 3+STABLE_TICKS·TICK_M cycles after a clean `sw` change. The first tick falls at an arbitrary phase.
- `rise`/`fall` pulse width is exactly 1 cycle. The pulse is high in the first cycle `db` shows its new value.
- Tick and bounce in the same cycle: the bounce wins and cnt is not incremented.

## Test plan
Use N=2, TICK_M=4, STABLE_TICKS=3 unless stated.
- Reset: hold `reset` for 2 cycles with `sw`=2'b11. Required: `db`=0, `rise`=0, `fall`=0 during reset. `db[0]` and `db[1]` go high between cycles 10 and 15 after reset release, each with exactly one 1-cycle `rise`.
- Clean press/release on channel 0: `sw[0]` 0→1, held 20 cycles, then 1→0. Required: `db[0]` rises 10–15 cycles after press, with one `rise[0]` pulse. `db[0]` falls 10–15 cycles after release, with one `fall[0]` pulse. `db[1]` stays 0.
- Bounce rejection: `sw[0]` toggled every 3 cycles for 60 cycles, then held 1. Required: no `db[0]` change and no pulses during toggling. After the hold, `db[0]`=1 within 15 cycles.
- Short glitch: `sw[1]`=1 for 6 cycles, then 0. Required: `db[1]` stays 0 with no `rise[1]`. Repeat in state ONE with a 6-cycle low: `db[1]` stays 1 with no `fall[1]`.
- Reset mid-operation: assert `reset` while channel 0 is in WAIT1 with cnt=2, and again while `db[0]`=1. Required: the next cycle shows `db`=0 with no `rise` or `fall`, and the tick counter restarts at 0.
- Simultaneous channels: both `sw` bits rise together and stay high. Required: `db`=2'b11 and `rise`=2'b11 on the same cycle.
